// File: rtl/dmem_lsu.sv
// dmem_lsu: single-port data-memory load/store unit.
// Byte/half/word loads with sign or zero extension; sub-word stores are done
// as read-modify-write on the addressed little-endian lanes.
// Optional build macro DMEM_LSU_ALIGN_CHECK_EN rejects misaligned half/word
// accesses the same way as an illegal size.
module dmem_lsu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUS_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  wr,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [BUS_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_e;

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [1:0]            size_q, size_d;
  logic                  sext_q, sext_d;
  logic [1:0]            off_q, off_d;
  logic [BUS_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  re_q, re_d;
  logic                  we_q, we_d;

  logic                  reject_c;
  logic [4:0]            lane_sh_c;
  logic [DATA_WIDTH-1:0] lane_mask_c;
  logic [DATA_WIDTH-1:0] lane_data_c;
  logic [DATA_WIDTH-1:0] load_c;
  logic [DATA_WIDTH-1:0] merged_c;
  logic                  unused_c;

  assign unused_c = ^addr[DATA_WIDTH-1:BUS_WIDTH+2];

  // Request rejection: illegal size, plus misalignment when checking is built in
  always_comb begin
    reject_c = (size == SZ_ILL);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
    if ((size == SZ_HALF) && addr[0]) reject_c = 1'b1;
    if ((size == SZ_WORD) && (addr[1:0] != 2'b00)) reject_c = 1'b1;
`endif
  end

  // Lane selection, load extension and store merge for the latched access
  always_comb begin
    lane_sh_c   = 5'd0;
    lane_mask_c = '1;
    case (size_q)
      SZ_BYTE: begin
        lane_sh_c   = {off_q, 3'b000};
        lane_mask_c = DATA_WIDTH'(32'h0000_00FF) << lane_sh_c;
      end
      SZ_HALF: begin
        lane_sh_c   = {off_q[1], 4'b0000};
        lane_mask_c = DATA_WIDTH'(32'h0000_FFFF) << lane_sh_c;
      end
      default: ;
    endcase
    lane_data_c = mem_rdata >> lane_sh_c;
    case (size_q)
      SZ_BYTE: load_c = {{(DATA_WIDTH-8){sext_q & lane_data_c[7]}}, lane_data_c[7:0]};
      SZ_HALF: load_c = {{(DATA_WIDTH-16){sext_q & lane_data_c[15]}}, lane_data_c[15:0]};
      default: load_c = lane_data_c;
    endcase
    merged_c = (mem_rdata & ~lane_mask_c) | ((mem_wdata_q << lane_sh_c) & lane_mask_c);
  end

  // Next-state, latching and registered-output decode
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    size_d      = size_q;
    sext_d      = sext_q;
    off_d       = off_q;
    addr_d      = addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d        = wr;
          size_d      = size;
          sext_d      = sign_ext;
          off_d       = addr[1:0];
          addr_d      = addr[BUS_WIDTH+1:2];
          mem_wdata_d = wdata;
          if (reject_c) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (wr && (size == SZ_WORD)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:   state_d = S_WAIT;
      S_WAIT: begin
        if (wr_q) begin
          mem_wdata_d = merged_c;
          state_d     = S_WR;
        end else begin
          rdata_d = load_c;
          state_d = S_DONE;
        end
      end
      S_WR:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    re_d   = (state_d == S_RD);
    we_d   = (state_d == S_WR);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      sext_q      <= 1'b0;
      off_q       <= 2'b00;
      addr_q      <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      off_q       <= off_d;
      addr_q      <= addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      re_q        <= re_d;
      we_q        <= we_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: randomized bench for dmem_lsu against a word-array memory model.
module tb_dmem_lsu;

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 24;

  logic          clk = 1'b0;
  logic          rst, req, wr, sign_ext, mem_init;
  logic [1:0]    size;
  logic [DW-1:0] addr, wdata, rdata, mem_wdata, mem_rdata;
  logic          busy, done, err, mem_re, mem_we;
  logic [BW-1:0] mem_addr;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] rdata_exp;
  logic [31:0] got;

  always #5 clk = ~clk;

  dmem_lsu #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h0101_0101 ^ 32'h5A3C_9618;
  endfunction

  // Memory: read data valid the cycle after mem_re, garbage otherwise
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (mem_we) begin
      mem[mem_addr[3:0]] <= mem_wdata;
    end
    mem_rdata <= mem_re ? mem[mem_addr[3:0]] : $urandom;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                              input logic sx, input logic [31:0] a);
    int unsigned v;
    int unsigned k;
    if (sz == 2'b00) begin
      k = 32'(a[1:0]);
      v = (w >> (8 * k)) % 256;
      if (sx && v >= 128) v = v - 256;
    end else if (sz == 2'b01) begin
      k = 32'(a[1]);
      v = (w >> (16 * k)) % 65536;
      if (sx && v >= 32768) v = v - 65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [31:0] a, input logic [31:0] d);
    int unsigned k, base, old_v, new_v;
    if (sz == 2'b00) begin
      k = 32'(a[1:0]); base = 1 << (8 * k);
      old_v = (w >> (8 * k)) % 256; new_v = d % 256;
    end else begin
      k = 32'(a[1]); base = 1 << (16 * k);
      old_v = (w >> (16 * k)) % 65536; new_v = d % 65536;
    end
    return w - old_v * base + new_v * base;
  endfunction

  task automatic scramble();
    wr       = 1'($urandom);
    size     = 2'($urandom);
    sign_ext = 1'($urandom);
    addr     = $urandom;
    wdata    = $urandom;
  endtask

  // One transaction: predict, drive, observe strobes/latency, compare
  task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d, input bit hold,
                       output logic [31:0] rd);
    bit          rej;
    int          lat, re_exp, we_exp, done_cyc, re_n, we_n, busy_n, re_cyc, we_cyc;
    int          widx;
    logic        err_got;
    logic [23:0] maddr;
    widx = int'(a[5:2]);
    rej  = (sz == 2'b11);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
    if (sz == 2'b01 && a[0]) rej = 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00) rej = 1'b1;
`endif
    if (rej) begin
      lat = 1; re_exp = 0; we_exp = 0;
    end else if (!w) begin
      lat = 3; re_exp = 1; we_exp = 0;
      rdata_exp = model_load(ref_mem[widx], sz, sx, a);
    end else if (sz == 2'b10) begin
      lat = 2; re_exp = 0; we_exp = 1;
      ref_mem[widx] = d;
    end else begin
      lat = 4; re_exp = 1; we_exp = 3;
      ref_mem[widx] = model_store(ref_mem[widx], sz, a, d);
    end
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    @(posedge clk);
    done_cyc = 0; re_n = 0; we_n = 0; busy_n = 0; re_cyc = 0; we_cyc = 0;
    err_got = 1'b0; maddr = '0; rd = rdata;
    for (int c = 1; c <= 8; c++) begin
      #1;
      if (busy) busy_n++;
      if (mem_re) begin re_n++; re_cyc = c; maddr = mem_addr; end
      if (mem_we) begin we_n++; we_cyc = c; maddr = mem_addr; end
      if (done) begin done_cyc = c; err_got = err; rd = rdata; end
      req = hold;
      scramble();
      if (done_cyc != 0) break;
      @(posedge clk);
    end
    check_eq("done_latency", 32'(done_cyc), 32'(lat));
    check_eq("err", 32'(err_got), 32'(rej));
    check_eq("busy_cycles", 32'(busy_n), 32'(lat));
    check_eq("re_count", 32'(re_n), (re_exp != 0) ? 32'd1 : 32'd0);
    check_eq("re_cycle", 32'(re_cyc), 32'(re_exp));
    check_eq("we_count", 32'(we_n), (we_exp != 0) ? 32'd1 : 32'd0);
    check_eq("we_cycle", 32'(we_cyc), 32'(we_exp));
    if (!rej) check_eq("mem_addr", 32'(maddr), 32'(a[25:2]));
    check_eq("rdata", rd, rdata_exp);
    @(posedge clk); #1;
    req = 1'b0;
    check_eq("idle_after_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check_eq("no_requeue", 32'({busy, done, mem_re, mem_we}), 32'd0);
    check_eq("mem_word", mem[widx], ref_mem[widx]);
  endtask

  initial begin
    int saw;
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; wdata = '0; mem_init = 1'b1; rdata_exp = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_strobes", 32'({mem_re, mem_we}), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    // Directed scenarios
    do_op(1'b1, 2'b10, 1'b0, 32'h0, 32'hABCDFE01, 1'b0, got);
    do_op(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, got);
    check_eq("word_roundtrip", got, 32'hABCDFE01);
    do_op(1'b1, 2'b10, 1'b0, 32'h4, 32'hFFFFAAAA, 1'b0, got);
    do_op(1'b1, 2'b00, 1'b0, 32'h6, 32'h0000005A, 1'b0, got);
    do_op(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, got);
    check_eq("byte_rmw", got, 32'hFF5AAAAA);
    do_op(1'b0, 2'b00, 1'b1, 32'h1, 32'h0, 1'b0, got);
    check_eq("lb_sext", got, 32'hFFFFFFFE);
    do_op(1'b0, 2'b00, 1'b0, 32'h1, 32'h0, 1'b0, got);
    check_eq("lb_zext", got, 32'h000000FE);
    do_op(1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 1'b0, got);
    check_eq("lh_sext", got, 32'hFFFFABCD);
    do_op(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 1'b0, got);
`ifndef DMEM_LSU_ALIGN_CHECK_EN
    check_eq("misaligned_word", got, 32'hABCDFE01);
`endif
    do_op(1'b0, 2'b11, 1'b1, 32'h8, 32'h0, 1'b1, got);
    do_op(1'b1, 2'b11, 1'b0, 32'h8, 32'h12345678, 1'b1, got);
    do_op(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1, got);
    do_op(1'b1, 2'b01, 1'b0, 32'hA, 32'h0000BEEF, 1'b1, got);

    // Reset while a load waits for memory data
    @(negedge clk);
    req = 1'b1; wr = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h4;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    rdata_exp = '0;
    check_eq("rst_wait_busy", 32'(busy), 32'd0);
    check_eq("rst_wait_rdata", rdata, 32'd0);
    saw = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || mem_re || mem_we) saw++;
    end
    check_eq("rst_wait_quiet", 32'(saw), 32'd0);
    do_op(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, got);

    // Reset coincident with the write strobe of a read-modify-write
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h11; wdata = 32'h000000C3;
    ref_mem[4] = model_store(ref_mem[4], 2'b00, 32'h11, 32'h000000C3);
    @(posedge clk); #1; req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rmw_we_before_rst", 32'(mem_we), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    saw = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || mem_re || mem_we || busy) saw++;
    end
    check_eq("rst_wr_quiet", 32'(saw), 32'd0);
    check_eq("rst_wr_mem", mem[4], ref_mem[4]);
    check_eq("rst_wr_rdata", rdata, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_op(1'($urandom), sz, 1'($urandom), 32'($urandom_range(0, 63)), $urandom,
            1'($urandom), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data word width.
REQ-002 Parameter BUS_WIDTH, default 24: memory word-address width.
REQ-003 clk  input  1  clock; all state changes on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  1  request valid; sampled only in IDLE.
REQ-006 wr  input  1  1 = store, 0 = load.
REQ-007 size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 addr  input  DATA_WIDTH  byte address.
REQ-010 wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-011 rdata  output  DATA_WIDTH  load result, extended, held until next load completes.
REQ-012 busy  output  1  high whenever state != IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  one-cycle pulse coincident with done on rejected request.
REQ-015 mem_re, mem_we  output  1 each  memory read/write strobes.
REQ-016 mem_addr  output  BUS_WIDTH  latched addr[BUS_WIDTH+1:2].
REQ-017 mem_wdata  output  DATA_WIDTH  full word to write.
REQ-018 mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle after mem_re.

Function
REQ-019 FSM states IDLE, RD, WAIT, WR, DONE; mem_re high only in RD, mem_we only in WR, done only in DONE.
REQ-020 On req in IDLE, addr/wr/size/sign_ext/wdata latched; inputs ignored afterwards until IDLE re-entered.
REQ-021 Word store: IDLE->WR->DONE; done 2 cycles after acceptance edge.
REQ-022 Load (any size): IDLE->RD->WAIT->DONE; mem_rdata captured at end of WAIT; done and rdata valid 3 cycles after acceptance.
REQ-023 Byte/half store: read-modify-write IDLE->RD->WAIT->WR->DONE; only addressed lanes replaced; done 4 cycles after acceptance.
REQ-024 Lanes little-endian: byte k = bits [8k+7:8k], k = addr[1:0]; half at addr[1]*16.
REQ-025 Load extension from selected lane MSB when sign_ext=1, else zero fill.
REQ-026 DONE always returns to IDLE next cycle; req during DONE or any busy cycle is dropped, not queued.
REQ-027 size=11: no memory access, IDLE->DONE, err=1, rdata unchanged.
REQ-028 err/rejected requests never assert mem_re or mem_we.

Reset
REQ-029 rst sampled high forces IDLE next cycle regardless of state; pending operation abandoned, no done.
REQ-030 After reset: busy, done, err, mem_re, mem_we = 0; rdata, mem_addr, mem_wdata = 0.
REQ-031 A mem_we high at the same edge rst is sampled is a completed write; no further memory access follows.

Configuration
REQ-032 Macro DMEM_LSU_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 rejected as REQ-027 (IDLE->DONE, err=1).
REQ-033 Macro undefined: no alignment check; misaligned half uses lane addr[1], misaligned word ignores addr[1:0]; err only for size=11.

Verification
REQ-034 Word store 0xABCDFE01 @0x0, then word load @0x0 -> rdata=0xABCDFE01; done at +2 (store) and +3 (load) cycles.
REQ-035 Word @0x4=0xFFFFAAAA, byte store 0x5A @0x6 -> word @0x4 = 0xFF5AAAAA; mem_re at +1, mem_we at +3, done at +4.
REQ-036 Word @0x0=0xABCDFE01: byte load @0x1 sign_ext=1 -> 0xFFFFFFFE; sign_ext=0 -> 0x000000FE; half load @0x2 sign_ext=1 -> 0xFFFFABCD.
REQ-037 Word load @0x2: with DMEM_LSU_ALIGN_CHECK_EN -> done+err at +1, no mem strobe; without -> rdata = word @0x0, err=0.
REQ-038 rst pulsed in WAIT of a load -> busy=0 next cycle, done never pulses, rdata=0; subsequent load completes normally.
REQ-039 req held high during busy/DONE -> exactly one operation per IDLE acceptance; size=11 -> done+err at +1, no memory access.
